// File: rtl/z80_mem_responder.sv
// Memory-side responder for the z80 bus: serves nRD/nWR strobes from an internal byte RAM,
// inserts WAIT_STATES wait cycles per access and reports access counts and protocol errors.
module z80_mem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic [15:0] A,
    input  logic        nRD,
    input  logic        nWR,
    input  logic [7:0]  WRITE_D,
    output logic [7:0]  READ_D,
    output logic        nWAIT,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        bus_error
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam bit NO_WAIT = (WAIT_STATES == 0);
    // The start edge itself counts as the first wait cycle, so the counter is preloaded one short.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        HOLD
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic prevRd_q, prevWr_q;
    logic [7:0] readD_q, readD_d;
    logic [15:0] rdCount_q, rdCount_d;
    logic [15:0] wrCount_q, wrCount_d;
    logic busError_q, busError_d;

    logic rdLow, wrLow, bothLow, rdStart, wrStart;
    logic doRead, doWrite;
    logic [ADDR_BITS-1:0] memAddr;
    logic [7:0] mem [DEPTH];
    logic unusedAddrHi;

    assign rdLow   = !nRD;
    assign wrLow   = !nWR;
    assign bothLow = rdLow && wrLow;
    assign rdStart = rdLow && prevRd_q;
    assign wrStart = wrLow && prevWr_q;
    assign memAddr = A[ADDR_BITS-1:0];
    assign unusedAddrHi = ^A[15:ADDR_BITS];

    // Next-state logic: starts, wait countdown, completion, abort and protocol checking.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busError_d = busError_q || bothLow;
        doRead     = 1'b0;
        doWrite    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bothLow && rdStart) begin
                    if (NO_WAIT) begin
                        doRead  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = RD_WAIT;
                    end
                end else if (!bothLow && wrStart) begin
                    if (NO_WAIT) begin
                        doWrite = 1'b1;
                        state_d = HOLD;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = WR_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (!rdLow || bothLow) begin
                    busError_d = 1'b1;
                    state_d    = IDLE;
                end else if (cnt_q == 4'd0) begin
                    doRead  = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_WAIT: begin
                if (!wrLow || bothLow) begin
                    busError_d = 1'b1;
                    state_d    = IDLE;
                end else if (cnt_q == 4'd0) begin
                    doWrite = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (!rdLow && !wrLow) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates driven by the completion decisions above.
    always_comb begin
        readD_d   = readD_q;
        rdCount_d = rdCount_q;
        wrCount_d = wrCount_q;
        if (doRead) begin
            readD_d   = mem[memAddr];
            rdCount_d = (rdCount_q == 16'hFFFF) ? rdCount_q : rdCount_q + 16'd1;
        end
        if (doWrite) begin
            wrCount_d = (wrCount_q == 16'hFFFF) ? wrCount_q : wrCount_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (nRESET) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            prevRd_q   <= 1'b1;
            prevWr_q   <= 1'b1;
            readD_q    <= 8'h00;
            rdCount_q  <= 16'd0;
            wrCount_q  <= 16'd0;
            busError_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prevRd_q   <= nRD;
            prevWr_q   <= nWR;
            readD_q    <= readD_d;
            rdCount_q  <= rdCount_d;
            wrCount_q  <= wrCount_d;
            busError_q <= busError_d;
        end
    end

    // RAM keeps its contents across reset; a write on a reset edge is abandoned.
    always_ff @(posedge clk) begin
        if (doWrite && !nRESET) begin
            mem[memAddr] <= WRITE_D;
        end
    end

    assign READ_D    = readD_q;
    assign nWAIT     = !((state_q == RD_WAIT) || (state_q == WR_WAIT));
    assign rd_count  = rdCount_q;
    assign wr_count  = wrCount_q;
    assign bus_error = busError_q;

endmodule

// File: tb/tb_z80_mem_responder.sv
// Bench for z80_mem_responder: a zero-wait and a three-wait instance share one bus and are
// compared against a per-instance model of memory contents, counters and access latency.
module tb_z80_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nRESET;
    logic [15:0] A;
    logic        nRD, nWR;
    logic [7:0]  WRITE_D;

    logic [7:0]  readD0, readD3;
    logic        nWait0, nWait3;
    logic [15:0] rdCnt0, rdCnt3, wrCnt0, wrCnt3;
    logic        busErr0, busErr3;

    z80_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) u0 (
        .clk(clk), .nRESET(nRESET), .A(A), .nRD(nRD), .nWR(nWR), .WRITE_D(WRITE_D),
        .READ_D(readD0), .nWAIT(nWait0), .rd_count(rdCnt0), .wr_count(wrCnt0), .bus_error(busErr0)
    );

    z80_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(3)) u3 (
        .clk(clk), .nRESET(nRESET), .A(A), .nRD(nRD), .nWR(nWR), .WRITE_D(WRITE_D),
        .READ_D(readD3), .nWAIT(nWait3), .rd_count(rdCnt3), .wr_count(wrCnt3), .bus_error(busErr3)
    );

    int checks = 0;
    int failures = 0;

    // Reference model, index 0 = zero-wait instance, index 1 = three-wait instance.
    int          waitOf [2] = '{0, 3};
    logic [7:0]  modelMem [2][256];
    logic [7:0]  modelReadD [2];
    int          modelRd [2];
    int          modelWr [2];
    logic        modelErr [2];
    logic [15:0] written [$];

    function automatic int satInc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            modelReadD[d] = 8'h00;
            modelRd[d]    = 0;
            modelWr[d]    = 0;
            modelErr[d]   = 1'b0;
        end
    endtask

    task automatic modelComplete(input int d, input bit isWrite, input logic [15:0] addr,
                                 input logic [7:0] data);
        if (isWrite) begin
            modelMem[d][addr[7:0]] = data;
            modelWr[d] = satInc(modelWr[d]);
        end else begin
            modelReadD[d] = modelMem[d][addr[7:0]];
            modelRd[d] = satInc(modelRd[d]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkDut(input int d, input logic expWait, input string tag);
        logic [7:0]  rdv;
        logic        nw;
        logic [15:0] rc;
        logic [15:0] wc;
        logic        be;
        string       t;
        rdv = (d == 0) ? readD0  : readD3;
        nw  = (d == 0) ? nWait0  : nWait3;
        rc  = (d == 0) ? rdCnt0  : rdCnt3;
        wc  = (d == 0) ? wrCnt0  : wrCnt3;
        be  = (d == 0) ? busErr0 : busErr3;
        t   = $sformatf("%s ws%0d", tag, waitOf[d]);
        checkOutput({t, " READ_D"},    16'(rdv), 16'(modelReadD[d]));
        checkOutput({t, " nWAIT"},     16'(nw),  16'(expWait));
        checkOutput({t, " rd_count"},  rc,       16'(modelRd[d]));
        checkOutput({t, " wr_count"},  wc,       16'(modelWr[d]));
        checkOutput({t, " bus_error"}, 16'(be),  16'(modelErr[d]));
    endtask

    // One full access: strobe held low long enough for the slowest instance, then released.
    task automatic applyStimulus(input bit isWrite, input logic [15:0] addr, input logic [7:0] data,
                                 input string tag);
        A = addr;
        WRITE_D = data;
        if (isWrite) nWR = 1'b0;
        else nRD = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                if (k == waitOf[d]) modelComplete(d, isWrite, addr, data);
                checkDut(d, (k >= waitOf[d]), $sformatf("%s k%0d", tag, k));
            end
        end
        nRD = 1'b1;
        nWR = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) checkDut(d, 1'b1, {tag, " release"});
        if (isWrite) written.push_back(addr);
    endtask

    initial begin
        logic [15:0] addr;
        logic [7:0]  data;
        bit          isWrite;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) modelMem[d][i] = 8'h00;
        modelReset();

        nRESET = 1'b1;
        nRD = 1'b1;
        nWR = 1'b1;
        A = 16'h0000;
        WRITE_D = 8'h00;
        tick();
        tick();
        for (int d = 0; d < 2; d++) checkDut(d, 1'b1, "reset");
        nRESET = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) checkDut(d, 1'b1, "idle");

        applyStimulus(1'b1, 16'h0010, 8'h5A, "t1 wr");
        applyStimulus(1'b0, 16'h0010, 8'h00, "t1 rd");
        checkOutput("t1 READ_D ws0", 16'(readD0), 16'h005A);
        checkOutput("t1 rd_count ws0", rdCnt0, 16'd1);
        checkOutput("t1 wr_count ws0", wrCnt0, 16'd1);

        applyStimulus(1'b1, 16'h1234, 8'hC3, "t3 wr");
        applyStimulus(1'b0, 16'hFF34, 8'h00, "t3 rd");
        checkOutput("t3 mirror ws0", 16'(readD0), 16'h00C3);
        checkOutput("t3 mirror ws3", 16'(readD3), 16'h00C3);

        for (int i = 0; i < 24; i++) begin
            isWrite = ($urandom_range(0, 1) == 1);
            if (isWrite) begin
                addr = 16'($urandom);
                data = 8'($urandom);
            end else begin
                addr = written[$urandom_range(0, written.size() - 1)];
                addr = {8'($urandom), addr[7:0]};
                data = 8'($urandom);
            end
            applyStimulus(isWrite, addr, data, $sformatf("rnd%0d", i));
        end

        nRD = 1'b0;
        nWR = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                modelErr[d] = 1'b1;
                checkDut(d, 1'b1, $sformatf("t5 both k%0d", k));
            end
        end
        nRD = 1'b1;
        nWR = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) checkDut(d, 1'b1, "t5 release");

        addr = 16'h0010;
        A = addr;
        nRD = 1'b0;
        tick();
        modelComplete(0, 1'b0, addr, 8'h00);
        checkDut(0, 1'b1, "t6 start");
        checkDut(1, 1'b0, "t6 start");
        tick();
        checkDut(0, 1'b1, "t6 wait");
        checkDut(1, 1'b0, "t6 wait");
        nRESET = 1'b1;
        nRD = 1'b1;
        tick();
        modelReset();
        for (int d = 0; d < 2; d++) checkDut(d, 1'b1, "t6 reset");
        nRESET = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) checkDut(d, 1'b1, "t6 after");
        applyStimulus(1'b0, addr, 8'h00, "t6 reread");

        addr = written[0];
        A = addr;
        WRITE_D = ~modelMem[1][addr[7:0]];
        nWR = 1'b0;
        tick();
        modelComplete(0, 1'b1, addr, WRITE_D);
        checkDut(0, 1'b1, "t4 start");
        checkDut(1, 1'b0, "t4 start");
        nWR = 1'b1;
        tick();
        modelErr[1] = 1'b1;
        for (int d = 0; d < 2; d++) checkDut(d, 1'b1, "t4 abort");
        tick();
        for (int d = 0; d < 2; d++) checkDut(d, 1'b1, "t4 idle");
        checkOutput("t4 bus_error ws3", 16'(busErr3), 16'd1);
        checkOutput("t4 wr_count ws3", wrCnt3, 16'd0);
        applyStimulus(1'b0, addr, 8'h00, "t4 rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
